key_debounce_array: RTL and testbench
=====================================

KEY_DEBOUNCE_ARRAY -- requirements
Module: key_debounce_array

Interface
REQ-001 Parameter N_CH, default 4, SHALL set the number of independent key channels (1..16).
REQ-002 Parameter TICK_DIV, default 50000, SHALL set the CLK cycles per sample tick (1 ms at 50 MHz); 1 means sample every cycle.
REQ-003 Parameter DB_TICKS, default 10, SHALL set the consecutive mismatching ticks needed to accept a level change (>=1).
REQ-004 Parameter RPT_DELAY, default 500, SHALL set the ticks from press to first repeat; 0 disables auto-repeat.
REQ-005 Parameter RPT_RATE, default 100, SHALL set the ticks between subsequent repeats (>=1).
REQ-006 Parameter ACTIVE_LOW, default 1, SHALL mean a raw input of 0 is "pressed".
REQ-007 CLK  input  1  SHALL be the single 50 MHz system clock; all logic is clocked on its rising edge.
REQ-008 RSTb  input  1  SHALL be the reset: synchronous, active-low.
REQ-009 key_raw  input  N_CH  SHALL carry the asynchronous, bouncing key inputs.
REQ-010 key_level  output  N_CH  SHALL carry the debounced pressed state (1 = pressed).
REQ-011 key_press  output  N_CH  SHALL carry a one-cycle pulse per accepted press.
REQ-012 key_release  output  N_CH  SHALL carry a one-cycle pulse per accepted release.
REQ-013 key_repeat  output  N_CH  SHALL carry a one-cycle auto-repeat pulse while a key is held.

Function
REQ-014 Each key_raw bit SHALL pass through a 2-flop synchroniser before any other use.
REQ-015 The synchronised value SHALL be normalised to pressed = sync XOR ACTIVE_LOW.
REQ-016 A shared prescaler SHALL count 0..TICK_DIV-1, assert tick for exactly one cycle at TICK_DIV-1, and wrap to 0.
REQ-017 Per channel on tick: pressed == key_level clears the debounce count; otherwise the count increments.
REQ-018 When a mismatching tick finds count == DB_TICKS-1, key_level SHALL toggle on that edge and the count SHALL clear.
REQ-019 Between ticks the debounce count SHALL hold; any mismatch shorter than DB_TICKS consecutive ticks SHALL leave key_level unchanged.
REQ-020 key_press or key_release SHALL be high in exactly the first cycle key_level is 1 or 0 after the toggle.
REQ-021 Latency with TICK_DIV=1 SHALL be exactly 2+DB_TICKS CLK edges from a clean raw change to key_level change.
REQ-022 Per-channel repeat FSM states: IDLE, DELAY, REPEAT.
REQ-023 IDLE -> DELAY on accepted press (repeat count cleared), only if RPT_DELAY != 0.
REQ-024 DELAY: count ticks; at tick count RPT_DELAY the FSM pulses key_repeat, clears count, enters REPEAT.
REQ-025 REPEAT: pulses key_repeat every RPT_RATE ticks.
REQ-026 Accepted release from any state SHALL return the FSM to IDLE in the same edge; no key_repeat is issued in that cycle or afterwards.
REQ-027 key_press and key_repeat SHALL never be high together on one channel.
REQ-028 Channels SHALL be fully independent; simultaneous pulses on several channels are legal.
REQ-029 The repeat count SHALL saturate, never wrap, at its terminal value.

Reset
REQ-030 While RSTb=0 at a rising edge: synchronisers load the not-pressed raw level, the prescaler and all counts clear, FSMs enter IDLE, and all outputs are 0.
REQ-031 Reset mid-bounce or mid-repeat SHALL discard all progress; no pulse is emitted in the first cycle after release of reset.
REQ-032 A key held through reset SHALL be reported as a fresh press 2+DB_TICKS ticks after reset release (TICK_DIV=1 timing).

Structure
REQ-033 Package key_pkg SHALL hold the rpt_state_t enum (IDLE, DELAY, REPEAT) and the default parameter constants.
REQ-034 Per-channel logic (synchroniser, debounce counter, repeat FSM, pulses) SHALL be sub-module key_channel, instantiated N_CH times by generate; the prescaler lives in the top.
REQ-035 Counter widths SHALL be $clog2 of their terminal values, minimum 1 bit.

Verification (TICK_DIV=1, DB_TICKS=3, RPT_DELAY=8, RPT_RATE=4, ACTIVE_LOW=1, N_CH=4)
REQ-036 Clean press: key_raw[0] 1->0 held -> key_level[0]=1 and key_press[0]=1 at edge 5, key_press low at edge 6.
REQ-037 Bounce: key_raw[1] low 2 cycles, high 1, low held -> no pulse during the bounce; single key_press 5 edges after the final fall.
REQ-038 Repeat: hold key 0 for 30 ticks after press -> key_repeat at press+8, +12, +16, +20, +24, +28; release -> one key_release and no further repeats.
REQ-039 Simultaneous: keys 2 and 3 fall on the same edge -> both key_press bits high in the same cycle.
REQ-040 Reset: assert RSTb=0 two ticks into a bounce on key 0 -> all outputs 0; with key still low, key_press again 5 edges after RSTb=1.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and default constants for the
// key debounce array.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rpt_state_t;

  localparam int N_CH_DEF       = 4;
  localparam int TICK_DIV_DEF   = 50000;
  localparam int DB_TICKS_DEF   = 10;
  localparam int RPT_DELAY_DEF  = 500;
  localparam int RPT_RATE_DEF   = 100;
  localparam bit ACTIVE_LOW_DEF = 1'b1;

  function automatic int cw(input int t);
    return (t > 1) ? $clog2(t) : 1;
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key: 2-flop synchroniser, tick-based debounce,
// press/release pulses and auto-repeat FSM.
module key_channel
  import key_pkg::*;
#(
  parameter int DB_TICKS   = DB_TICKS_DEF,
  parameter int RPT_DELAY  = RPT_DELAY_DEF,
  parameter int RPT_RATE   = RPT_RATE_DEF,
  parameter bit ACTIVE_LOW = ACTIVE_LOW_DEF
) (
  input  logic CLK,
  input  logic RSTb,
  input  logic tick_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int DW = cw(DB_TICKS);
  localparam int RMAX =
    (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
  localparam int RW = cw(RMAX);
  localparam int DB_LAST = DB_TICKS - 1;
  localparam int RD_LAST =
    (RPT_DELAY > 0) ? RPT_DELAY - 1 : 0;
  localparam int RR_LAST = RPT_RATE - 1;
  localparam logic IDLE_LVL = 1'(ACTIVE_LOW);

  logic [1:0]    sync_q, sync_d;
  logic [DW-1:0] db_q, db_d;
  logic [RW-1:0] rc_q, rc_d;
  rpt_state_t    st_q, st_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          rpt_q, rpt_d;
  logic          pressed;

  assign pressed = sync_q[1] ^ IDLE_LVL;

  always_comb begin
    sync_d  = {sync_q[0], raw_i};
    db_d    = db_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (tick_i) begin
      if (pressed == level_q) begin
        db_d = '0;
      end else if (db_q == DW'(DB_LAST)) begin
        db_d    = '0;
        level_d = ~level_q;
        press_d = pressed;
        rel_d   = ~pressed;
      end else begin
        db_d = db_q + DW'(1);
      end
    end
  end

  // Release wins over any repeat due on the same edge.
  always_comb begin
    st_d  = st_q;
    rc_d  = rc_q;
    rpt_d = 1'b0;
    if (rel_d) begin
      st_d = IDLE;
      rc_d = '0;
    end else begin
      unique case (st_q)
        IDLE: begin
          if (press_d && RPT_DELAY != 0) begin
            st_d = DELAY;
            rc_d = '0;
          end
        end
        DELAY: begin
          if (tick_i) begin
            if (rc_q == RW'(RD_LAST)) begin
              rpt_d = 1'b1;
              rc_d  = '0;
              st_d  = REPEAT;
            end else if (rc_q != '1) begin
              rc_d = rc_q + RW'(1);
            end
          end
        end
        REPEAT: begin
          if (tick_i) begin
            if (rc_q == RW'(RR_LAST)) begin
              rpt_d = 1'b1;
              rc_d  = '0;
            end else if (rc_q != '1) begin
              rc_d = rc_q + RW'(1);
            end
          end
        end
        default: begin
          st_d = IDLE;
          rc_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      sync_q  <= {2{IDLE_LVL}};
      db_q    <= '0;
      rc_q    <= '0;
      st_q    <= IDLE;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      rpt_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      db_q    <= db_d;
      rc_q    <= rc_d;
      st_q    <= st_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      rpt_q   <= rpt_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = rel_q;
  assign repeat_o  = rpt_q;

endmodule

// File: rtl/key_debounce_array.sv
// N_CH debounced keys sharing one sample-tick
// prescaler.
module key_debounce_array
  import key_pkg::*;
#(
  parameter int N_CH       = N_CH_DEF,
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int DB_TICKS   = DB_TICKS_DEF,
  parameter int RPT_DELAY  = RPT_DELAY_DEF,
  parameter int RPT_RATE   = RPT_RATE_DEF,
  parameter bit ACTIVE_LOW = ACTIVE_LOW_DEF
) (
  input  logic            CLK,
  input  logic            RSTb,
  input  logic [N_CH-1:0] key_raw,
  output logic [N_CH-1:0] key_level,
  output logic [N_CH-1:0] key_press,
  output logic [N_CH-1:0] key_release,
  output logic [N_CH-1:0] key_repeat
);

  localparam int PW = cw(TICK_DIV);

  logic [PW-1:0] pre_q, pre_d;
  logic          tick;

  assign tick = (pre_q == PW'(TICK_DIV - 1));

  always_comb begin
    pre_d = tick ? '0 : pre_q + PW'(1);
  end

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    key_channel #(
      .DB_TICKS  (DB_TICKS),
      .RPT_DELAY (RPT_DELAY),
      .RPT_RATE  (RPT_RATE),
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_ch (
      .CLK      (CLK),
      .RSTb     (RSTb),
      .tick_i   (tick),
      .raw_i    (key_raw[g]),
      .level_o  (key_level[g]),
      .press_o  (key_press[g]),
      .release_o(key_release[g]),
      .repeat_o (key_repeat[g])
    );
  end

endmodule

// File: tb/tb_key_debounce_array.sv
// Self-checking bench: timeline vector table plus
// hand-written reset sequences, via a scoreboard queue.
module tb_key_debounce_array;

  logic       CLK = 1'b0;
  logic       RSTb = 1'b0;
  logic [3:0] key_raw = 4'hF;
  logic [3:0] key_level;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic [3:0] key_repeat;

  key_debounce_array #(
    .N_CH      (4),
    .TICK_DIV  (1),
    .DB_TICKS  (3),
    .RPT_DELAY (8),
    .RPT_RATE  (4),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .CLK        (CLK),
    .RSTb       (RSTb),
    .key_raw    (key_raw),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_repeat (key_repeat)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         e;
    logic [3:0] raw;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
    logic [3:0] rpt;
  } vec_t;

  logic [15:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  vec_t tab[22];

  task automatic step(input string tag, input int e,
                      input logic [3:0] lvl,
                      input logic [3:0] prs,
                      input logic [3:0] rel,
                      input logic [3:0] rpt);
    logic [15:0] got;
    logic [15:0] want;
    exp_q.push_back({lvl, prs, rel, rpt});
    @(posedge CLK);
    #1;
    got  = {key_level, key_press, key_release, key_repeat};
    want = exp_q.pop_front();
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s edge %0d: got lvl/prs/rel/rpt=%b/%b/%b/%b want %b/%b/%b/%b",
               tag, e, got[15:12], got[11:8], got[7:4], got[3:0],
               want[15:12], want[11:8], want[7:4], want[3:0]);
    end
  endtask

  initial begin
    int k;
    logic [3:0] lv;
    tab[0]  = '{2,  4'b1110, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tab[1]  = '{7,  4'b1110, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    tab[2]  = '{15, 4'b1110, 4'b0001, 4'b0000, 4'b0000, 4'b0001};
    tab[3]  = '{19, 4'b1110, 4'b0001, 4'b0000, 4'b0000, 4'b0001};
    tab[4]  = '{23, 4'b1110, 4'b0001, 4'b0000, 4'b0000, 4'b0001};
    tab[5]  = '{27, 4'b1110, 4'b0001, 4'b0000, 4'b0000, 4'b0001};
    tab[6]  = '{31, 4'b1110, 4'b0001, 4'b0000, 4'b0000, 4'b0001};
    tab[7]  = '{32, 4'b1111, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    tab[8]  = '{35, 4'b1111, 4'b0001, 4'b0000, 4'b0000, 4'b0001};
    tab[9]  = '{37, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
    tab[10] = '{50, 4'b1101, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tab[11] = '{52, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tab[12] = '{53, 4'b1101, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tab[13] = '{58, 4'b1101, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
    tab[14] = '{59, 4'b1111, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
    tab[15] = '{64, 4'b1111, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
    tab[16] = '{70, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tab[17] = '{75, 4'b0011, 4'b1100, 4'b1100, 4'b0000, 4'b0000};
    tab[18] = '{83, 4'b0011, 4'b1100, 4'b0000, 4'b0000, 4'b1100};
    tab[19] = '{87, 4'b0011, 4'b1100, 4'b0000, 4'b0000, 4'b1100};
    tab[20] = '{88, 4'b1111, 4'b1100, 4'b0000, 4'b0000, 4'b0000};
    tab[21] = '{93, 4'b1111, 4'b0000, 4'b0000, 4'b1100, 4'b0000};

    // Power-on reset.
    RSTb = 1'b0;
    key_raw = 4'hF;
    for (int i = 0; i < 3; i++)
      step("reset", i, 4'h0, 4'h0, 4'h0, 4'h0);
    RSTb = 1'b1;

    // Timeline: press/repeat/release, bounce, simultaneous.
    k = 0;
    lv = 4'h0;
    for (int e = 1; e <= 105; e++) begin
      if (k < 22 && tab[k].e == e) begin
        lv = tab[k].lvl;
        step("table", e, tab[k].lvl, tab[k].prs,
             tab[k].rel, tab[k].rpt);
        key_raw = tab[k].raw;
        k++;
      end else if (e == 91) begin
        step("table", e, lv, 4'h0, 4'h0, 4'b1100);
      end else begin
        step("table", e, lv, 4'h0, 4'h0, 4'h0);
      end
    end

    // Reset two ticks into a bounce on key 0.
    key_raw = 4'b1110;
    for (int e = 1; e <= 4; e++)
      step("prebounce", e, 4'h0, 4'h0, 4'h0, 4'h0);
    RSTb = 1'b0;
    for (int e = 1; e <= 2; e++)
      step("rst_bounce", e, 4'h0, 4'h0, 4'h0, 4'h0);
    RSTb = 1'b1;
    for (int e = 1; e <= 4; e++)
      step("post_rst1", e, 4'h0, 4'h0, 4'h0, 4'h0);
    step("post_rst1", 5, 4'h1, 4'h1, 4'h0, 4'h0);

    // Into repeat, then reset mid-repeat.
    for (int e = 6; e <= 12; e++)
      step("hold1", e, 4'h1, 4'h0, 4'h0, 4'h0);
    step("hold1", 13, 4'h1, 4'h0, 4'h0, 4'h1);
    for (int e = 14; e <= 15; e++)
      step("hold1", e, 4'h1, 4'h0, 4'h0, 4'h0);
    RSTb = 1'b0;
    for (int e = 1; e <= 2; e++)
      step("rst_rpt", e, 4'h0, 4'h0, 4'h0, 4'h0);
    RSTb = 1'b1;
    for (int e = 1; e <= 4; e++)
      step("post_rst2", e, 4'h0, 4'h0, 4'h0, 4'h0);
    step("post_rst2", 5, 4'h1, 4'h1, 4'h0, 4'h0);
    for (int e = 6; e <= 12; e++)
      step("hold2", e, 4'h1, 4'h0, 4'h0, 4'h0);
    step("hold2", 13, 4'h1, 4'h0, 4'h0, 4'h1);

    // Release in REPEAT; one repeat still due before it lands.
    key_raw = 4'hF;
    for (int e = 14; e <= 16; e++)
      step("rel2", e, 4'h1, 4'h0, 4'h0, 4'h0);
    step("rel2", 17, 4'h1, 4'h0, 4'h0, 4'h1);
    step("rel2", 18, 4'h0, 4'h0, 4'h1, 4'h0);
    for (int e = 19; e <= 26; e++)
      step("rel2", e, 4'h0, 4'h0, 4'h0, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
